div_seq: RTL
============

# div_seq

Parametrised sequential integer divider for the multicycle CPU datapath. It serves both signed and unsigned divide instructions (DIV/DIVU) from one block, one quotient bit per cycle, using a non-restoring algorithm. Operands are latched at `start`; quotient and remainder are registered and held until the next accepted `start`. Results complete with a one-cycle `done` pulse, and divide-by-zero is flagged.

## Interface
- `WIDTH`, default 32: operand and result width; legal range 4 to 64.
- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `ena` input 1: block enable; while low, acts as a synchronous abort to IDLE.
- `start` input 1: request a divide; accepted only in IDLE with `ena`=1.
- `sign_mode` input 1: 1 selects signed (two's complement), 0 selects unsigned; latched at `start`.
- `dividend` input WIDTH: latched at accepted `start`.
- `divisor` input WIDTH: latched at accepted `start`.
- `q` output WIDTH: registered quotient.
- `r` output WIDTH: registered remainder.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when `q`, `r` and `dz` update.
- `dz` output 1: divide by zero on the last completed operation; held with `q` and `r`.

## Operation
- The FSM has three states: IDLE, RUN, FIX.
- **IDLE to RUN** on `start`&`ena`, divisor ≠ 0:
  - Latch |dividend| and |divisor|; magnitudes are taken only in signed mode.
  - Latch the quotient-sign flag (dividend MSB XOR divisor MSB) and the remainder-sign flag (dividend MSB), both signed mode only.
  - Clear the partial remainder (WIDTH+1 bits, which includes the sign bit). Clear the iteration counter.
- **RUN** executes one non-restoring step per cycle:
  - If the partial remainder ≥ 0: `{R,Q[MSB]}` − B.
  - Otherwise: `{R,Q[MSB]}` + B.
  - Shift the Q register left and insert the inverted sign of the result.
  - The counter is ⌈log2(WIDTH+1)⌉ bits. The last step is at count = WIDTH−1, then go to FIX.
- **FIX** (one cycle):
  - If the partial remainder is negative, add B back.
  - Negate Q if the quotient-sign flag is set. Negate R if the remainder-sign flag is set.
  - Write `q` and `r`; `dz`<=0; `done`<=1. Return to IDLE.
- **Divide by zero** (divisor = 0 at accepted `start`): go straight to FIX-equivalent completion.
  - Next cycle: `q` = all ones, `r` = dividend (unmodified), `dz`=1, `done`=1. Return to IDLE.
  - No RUN cycles occur; this applies in both modes.
- **Signed overflow** (most-negative ÷ −1): `q` = most-negative value (wraps), `r` = 0, `dz`=0. The normal path produces this; no special case is needed.
- Arithmetic results:
  - Signed mode truncates toward zero; the remainder takes the dividend's sign; \|r\| < \|divisor\|.
  - Unsigned mode: dividend = q·divisor + r, with 0 ≤ r < divisor.
- `start` while `busy`=1 is ignored; the operation in flight is unaffected.
- `ena`=0 (any state), on the next edge:
  - State goes to IDLE; `busy`<=0; `done`<=0.
  - `q`, `r`, `dz` hold their last values. The aborted operation never produces `done`.
- Input pins are not sampled after the `start` cycle; operands may change freely during RUN.

## Timing
- Reset values: `q`=0, `r`=0, `busy`=0, `done`=0, `dz`=0, state IDLE. Reset has priority over `ena` and `start`.
- Edge E0 is the edge that samples the accepted `start`.
  - E0: `busy` rises.
  - E1 through E_WIDTH: RUN steps.
  - E_WIDTH+1: FIX; `q`, `r` valid; `done`=1; `busy`=0.
- Latency is WIDTH+1 cycles. `busy` is high for exactly WIDTH+1 cycles.
- Divide-by-zero path:
  - E0: `busy`=1.
  - E1: results are written, `done`=1, `busy`=0.
- `done` is high for exactly one cycle and never coincides with `busy`=1.
- A new `start` may be asserted in the same cycle that `done` is high. It is accepted because the state is IDLE, giving back-to-back throughput of one divide per WIDTH+2 cycles.
- Reset or `ena`=0 mid-RUN: `busy`=0 after the next edge, and no `done` follows.

## Test plan
- **Signed small operands** (WIDTH=32, signed):
  - 7 ÷ −2 → q=0xFFFFFFFD (−3), r=1.
  - −7 ÷ 2 → q=−3, r=0xFFFFFFFF (−1).
  - For each: `done` at cycle 33 after `start`; `busy` high for 33 cycles.
- **Unsigned large operand**: 0xFFFFFFFF ÷ 16 → q=0x0FFFFFFF, r=15. The same operands in signed mode → q=0, r=0xFFFFFFFF.
- **Corner cases**:
  - Divide by zero: 0x12345678 ÷ 0, either mode → at cycle 1, q=0xFFFFFFFF, r=0x12345678, dz=1, `done`=1. The next normal divide clears dz.
  - Overflow: 0x80000000 ÷ 0xFFFFFFFF signed → q=0x80000000, r=0, dz=0.
- **Handshake**:
  - `start` pulsed with new operands at cycle 10 of a busy run → ignored; the first result is correct.
  - `start` in the `done` cycle → accepted; the second result arrives WIDTH+2 cycles after the first.
- **Abort and reset**:
  - `ena`=0 at cycle 15 → `busy`=0 next cycle; no `done`; `q`/`r` keep the previous result.
  - `reset` at cycle 15 → all outputs 0.
- **Parametrisation**: a WIDTH=8 instance with random signed and unsigned operand sweeps against a reference model. Check the latency of 9 cycles and the results −128 ÷ −1 → q=0x80, r=0.

Source files
------------

// File: rtl/div_seq.sv
// Sequential non-restoring integer divider, one quotient bit per cycle.
// Serves signed and unsigned divides; flags divide-by-zero and pulses done on completion.
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ena,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             accept;
    logic             div_zero;

    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] qr_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt;
    logic             qsign;
    logic             rsign;
    logic             dz_pend;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes and result signs; only meaningful in signed mode
    always_comb begin
        div_zero = (divisor == '0);
        dvd_neg  = sign_mode & dividend[WIDTH-1];
        dvs_neg  = sign_mode & divisor[WIDTH-1];
        dvd_mag  = dvd_neg ? -dividend : dividend;
        dvs_mag  = dvs_neg ? -divisor  : divisor;
    end

    // One non-restoring step, plus the final remainder correction and sign fix-up
    always_comb begin
        shifted = {a_reg[WIDTH-1:0], qr_reg[WIDTH-1]};
        b_ext   = {1'b0, b_reg};
        a_step  = a_reg[WIDTH] ? (shifted + b_ext) : (shifted - b_ext);
        r_mag   = a_reg[WIDTH-1:0] + (a_reg[WIDTH] ? b_reg : '0);
        q_fix   = qsign ? -qr_reg : qr_reg;
        r_fix   = rsign ? -r_mag  : r_mag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ena low forces an abort back to IDLE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        if (!ena) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        accept    = 1'b1;
                        state_nxt = div_zero ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt == LAST) begin
                        state_nxt = S_FIX;
                    end
                end
                S_FIX: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg   <= '0;
            qr_reg  <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            qsign   <= 1'b0;
            rsign   <= 1'b0;
            dz_pend <= 1'b0;
            q       <= '0;
            r       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!ena) begin
                busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            busy    <= 1'b1;
                            a_reg   <= '0;
                            cnt     <= '0;
                            b_reg   <= dvs_mag;
                            qsign   <= dvd_neg ^ dvs_neg;
                            rsign   <= dvd_neg;
                            dz_pend <= div_zero;
                            // Divide-by-zero reports the raw dividend as remainder
                            qr_reg  <= div_zero ? dividend : dvd_mag;
                        end
                    end
                    S_RUN: begin
                        a_reg  <= a_step;
                        qr_reg <= {qr_reg[WIDTH-2:0], ~a_step[WIDTH]};
                        cnt    <= cnt + CW'(1);
                    end
                    S_FIX: begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        if (dz_pend) begin
                            q  <= '1;
                            r  <= qr_reg;
                            dz <= 1'b1;
                        end else begin
                            q  <= q_fix;
                            r  <= r_fix;
                            dz <= 1'b0;
                        end
                    end
                    default: begin
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
